serial_add_ctrl: RTL and testbench

- Bit-serial adder/subtractor controller. It sequences a single 1-bit full-adder cell over WIDTH cycles, LSB first, with a registered carry.
- It accepts WIDTH-bit operands through a start/busy/done handshake and returns a WIDTH-bit result, carry-out and signed-overflow flag.
- It lets the team reuse the one-bit adder datapath for multi-bit arithmetic at minimal area.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/fa_cell.sv | 18 +
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, the only arithmetic in the serial datapath.
// Latency: purely combinational.
// Backpressure: none.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walked over WIDTH bits, LSB first.
// Latency: done is high in the (WIDTH+1)th cycle after the start edge; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded status outputs; encoding 3 falls back to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                busy      = 1'b1;
                state_nxt = last_bit ? S_DONE : S_RUN;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, serial shift/carry datapath and result capture on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert B and force the carry-in.
                        a_sr  <= a_in;
                        b_sr  <= sub ? ~b_in : b_in;
                        carry <= sub ? 1'b1 : cin_in;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Outputs land as DONE is entered so they are valid alongside done.
                        // Here carry is the carry into the MSB, fa_co the carry out of it.
                        sum_out  <= {fa_s, r_sr[WIDTH-1:1]};
                        cout_out <= fa_co;
                        ovf_out  <= carry ^ fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .ovf_out  (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns edges seen since the call.
    task automatic wait_done(input string tag, input bit chk_busy, output int k);
        k = 0;
        while (!done && k < 20) begin
            if (chk_busy) check({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    // One full operation; inputs driven just after an edge, start edge is the next one.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input logic [W-1:0] es,
                          input logic ec, input logic eo, input bit chk_lat);
        int k;
        start  = 1'b1;
        sub    = s;
        a_in   = a;
        b_in   = b;
        cin_in = c;
        tick();
        start  = 1'b0;
        a_in   = 8'hAA;
        b_in   = 8'h55;
        cin_in = 1'b1;
        wait_done(tag, chk_lat, k);
        if (chk_lat) check({tag, "_latency"}, 32'(k), 32'd8);
        check({tag, "_sum"}, 32'(sum_out), 32'(es));
        check({tag, "_cout"}, 32'(cout_out), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf_out), 32'(eo));
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum_out), 32'(es));
    endtask

    initial begin
        int k;
        int t1;
        int t2;
        int ndone;

        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout_out), 32'd0);
        check("rst_ovf", 32'(ovf_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Additions.
        run_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_ff_00_c1", 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("add_a5_3c_c1", 1'b0, 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);

        // Subtractions; cin_in must be ignored.
        run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("sub_00_00", 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Start pulsed while busy is dropped.
        start = 1'b1; sub = 1'b0; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a_in = 8'h10; b_in = 8'h10;
        tick();
        start = 1'b0;
        wait_done("busy_start", 1'b0, k);
        check("busy_start_sum", 32'(sum_out), 32'h02);
        ndone = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            tick();
        end
        check("busy_start_no_second", 32'(ndone), 32'd0);
        check("busy_start_sum_hold", 32'(sum_out), 32'h02);

        // Start held high: back-to-back ops, WIDTH+2 cycles apart.
        start = 1'b1; sub = 1'b0; a_in = 8'h03; b_in = 8'h04; cin_in = 1'b0;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done && t1 < 0) t1 = i;
            else if (done && t2 < 0) t2 = i;
            if (t2 >= 0) break;
        end
        start = 1'b0;
        check("b2b_first_seen", 32'(t1 >= 0), 32'd1);
        check("b2b_spacing", 32'(t2 - t1), 32'd10);
        check("b2b_sum", 32'(sum_out), 32'h07);
        tick();
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        // Mid-operation reset, on the 4th RUN cycle.
        start = 1'b1; sub = 1'b1; a_in = 8'h80; b_in = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_busy_before", 32'(busy), 32'd1);
        check("midrst_sum_before", 32'(sum_out), 32'h07);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum_out), 32'd0);
        check("midrst_cout", 32'(cout_out), 32'd0);
        check("midrst_ovf", 32'(ovf_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
